boxcar_interpolator: RTL and testbench

- Rate-increasing counterpart of the moving-average (boxcar) decimating filter: accepts one low-rate sample and emits INTERP_RATE high-rate samples.
- Implemented as a multi-stage CIC interpolator: NUM_STAGES comb stages at the input rate, then zero-stuffing, then NUM_STAGES integrator stages at the output rate.
- Sits on the DAC/upsampling path of the DSP chain and uses the same i_ce/o_ce strobe style as the averaging filters.

---
 rtl/boxcar_interpolator_if.sv | 27 ++
 rtl/boxcar_interpolator.sv | 110 +++++++++++
 tb/tb_boxcar_interpolator.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/boxcar_interpolator_if.sv
// Sample-in / interpolated-samples-out bus of the boxcar (CIC) interpolator.
// The slave side is the filter, and the master side is whoever feeds it.
interface boxcar_interpolator_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int INTERP_RATE = 4,
   parameter int NUM_STAGES  = 2
) ();
   localparam int LOG2_RATE = $clog2(INTERP_RATE);
   localparam int OUT_WIDTH = DATA_WIDTH + (NUM_STAGES - 1) * LOG2_RATE;

   logic                         i_ce;
   logic signed [DATA_WIDTH-1:0] i_data;
   logic                         o_ready;
   logic signed [OUT_WIDTH-1:0]  o_data;
   logic                         o_ce;
   logic [LOG2_RATE-1:0]         o_phase;

   modport master (
      output i_ce, i_data,
      input  o_ready, o_data, o_ce, o_phase
   );

   modport slave (
      input  i_ce, i_data,
      output o_ready, o_data, o_ce, o_phase
   );
endinterface

// File: rtl/boxcar_interpolator.sv
// CIC interpolator: NUM_STAGES combs at the input rate, then zero-stuffing,
// then NUM_STAGES integrators that run once per output sample in a burst.
module boxcar_interpolator #(
   parameter int DATA_WIDTH  = 8,
   parameter int INTERP_RATE = 4,
   parameter int NUM_STAGES  = 2,
   parameter int LOG2_RATE   = $clog2(INTERP_RATE),
   parameter int OUT_WIDTH   = DATA_WIDTH + (NUM_STAGES - 1) * LOG2_RATE
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   boxcar_interpolator_if.slave  bus
);

   typedef enum logic {IDLE, BURST} state_t;

   localparam logic [LOG2_RATE-1:0] LAST_PHASE = LOG2_RATE'(INTERP_RATE - 1);

   state_t                                state_q, state_d;
   logic [LOG2_RATE-1:0]                  phase_q, phase_d;
   logic [NUM_STAGES-1:0][OUT_WIDTH-1:0]  comb_dly_q, comb_dly_d;
   logic [OUT_WIDTH-1:0]                  stuffed_q, stuffed_d;
   logic [NUM_STAGES-1:0][OUT_WIDTH-1:0]  integ_q, integ_d;
   logic [OUT_WIDTH-1:0]                  o_data_q, o_data_d;
   logic                                  o_ce_q, o_ce_d;

   logic [NUM_STAGES:0][OUT_WIDTH-1:0]    comb_c;
   logic [NUM_STAGES-1:0][OUT_WIDTH-1:0]  integ_new;
   logic                                  ready;
   logic                                  accept;

   // All arithmetic is modular at OUT_WIDTH; intermediate wrap cancels out.
   always_comb begin
      comb_c[0] = OUT_WIDTH'(bus.i_data);
      for (int k = 0; k < NUM_STAGES; k++)
         comb_c[k+1] = comb_c[k] - comb_dly_q[k];
   end

   // Integrators chain on the freshly computed value of the stage before,
   // so an accepted sample shows up at the output on the very next cycle.
   always_comb begin
      integ_new[0] = integ_q[0] + ((phase_q == '0) ? stuffed_q : '0);
      for (int k = 1; k < NUM_STAGES; k++)
         integ_new[k] = integ_q[k] + integ_new[k-1];
   end

   assign ready  = (state_q == IDLE) || (state_q == BURST && phase_q == LAST_PHASE);
   assign accept = bus.i_ce && ready;

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      comb_dly_d = comb_dly_q;
      stuffed_d  = stuffed_q;
      integ_d    = integ_q;
      o_data_d   = o_data_q;
      o_ce_d     = 1'b0;

      if (accept) begin
         for (int k = 0; k < NUM_STAGES; k++)
            comb_dly_d[k] = comb_c[k];
         stuffed_d = comb_c[NUM_STAGES];
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               phase_d = '0;
               state_d = BURST;
            end
         end
         BURST: begin
            integ_d  = integ_new;
            o_data_d = integ_new[NUM_STAGES-1];
            o_ce_d   = 1'b1;
            phase_d  = phase_q + 1'b1;
            // Last phase without a new sample ends the burst; with one, stream on.
            if (phase_q == LAST_PHASE && !accept)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= IDLE;
         phase_q    <= '0;
         comb_dly_q <= '0;
         stuffed_q  <= '0;
         integ_q    <= '0;
         o_data_q   <= '0;
         o_ce_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         comb_dly_q <= comb_dly_d;
         stuffed_q  <= stuffed_d;
         integ_q    <= integ_d;
         o_data_q   <= o_data_d;
         o_ce_q     <= o_ce_d;
      end
   end

   assign bus.o_ready = ready;
   assign bus.o_data  = o_data_q;
   assign bus.o_ce    = o_ce_q;
   assign bus.o_phase = phase_q;

endmodule

// File: tb/tb_boxcar_interpolator.sv
// Directed bench for boxcar_interpolator at default parameters (8-bit, x4, 2 stages).
module tb_boxcar_interpolator;
   localparam int DW = 8;

   logic i_clk = 1'b0;
   logic i_reset_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   boxcar_interpolator_if #(.DATA_WIDTH(8), .INTERP_RATE(4), .NUM_STAGES(2)) bus ();

   boxcar_interpolator #(.DATA_WIDTH(8), .INTERP_RATE(4), .NUM_STAGES(2)) dut (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .bus       (bus)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input integer obs, input integer exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic ce, input int d);
      bus.i_ce   = ce;
      bus.i_data = DW'(d);
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      bus.i_ce  = 1'b0;
      i_reset_n = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      i_reset_n = 1'b1;
   endtask

   task automatic chk_out(input string tag, input integer ce, input integer data);
      chk({tag, "_ce"},   integer'(bus.o_ce), ce);
      chk({tag, "_data"}, integer'($signed(bus.o_data)), data);
   endtask

   // Impulse followed by streamed zeros gives the x4 triangle.
   task automatic run_tri(input string tag);
      int tri_exp [8] = '{1, 2, 3, 4, 3, 2, 1, 0};
      step(1'b1, 1);
      chk({tag, "_first_ce"}, integer'(bus.o_ce), 0);
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 0);
         chk_out($sformatf("%s_k%0d", tag, k), 1, tri_exp[k-1]);
         chk($sformatf("%s_rdy%0d", tag, k), integer'(bus.o_ready), (k % 4 == 3) ? 1 : 0);
      end
      repeat (5) step(1'b0, 0);
      chk_out({tag, "_drained"}, 0, 0);
      chk({tag, "_drained_rdy"}, integer'(bus.o_ready), 1);
   endtask

   initial begin
      int bp_in  [12] = '{1, 50, -50, 77, 2, 99, -99, 33, 1, -7, 64, -128};
      int bp_exp [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4};

      bus.i_ce   = 1'b0;
      bus.i_data = '0;
      #1;
      chk_out("rst", 0, 0);
      chk("rst_rdy",   integer'(bus.o_ready), 1);
      chk("rst_phase", integer'(bus.o_phase), 0);
      repeat (2) @(posedge i_clk);
      #1;
      i_reset_n = 1'b1;

      // Constant 1 streamed gaplessly
      step(1'b1, 1);
      for (int k = 1; k <= 12; k++) begin
         step(1'b1, 1);
         chk_out($sformatf("const_k%0d", k), 1, (k < 4) ? k : 4);
      end

      do_reset();
      run_tri("tri");

      // Full scale, both polarities
      do_reset();
      step(1'b1, 127);
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 127);
         chk_out($sformatf("pos_k%0d", k), 1, 127 * ((k < 4) ? k : 4));
      end
      do_reset();
      step(1'b1, -128);
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, -128);
         chk_out($sformatf("neg_k%0d", k), 1, -128 * ((k < 4) ? k : 4));
      end

      // Backpressure: only inputs 0, 4, 8 (values 1, 2, 1) are taken
      do_reset();
      for (int k = 0; k < 12; k++) begin
         step(1'b1, bp_in[k]);
         chk($sformatf("bp_phase%0d", k), integer'(bus.o_phase), k % 4);
         if (k >= 1)
            chk_out($sformatf("bp_k%0d", k), 1, bp_exp[k-1]);
      end
      step(1'b0, 0);
      chk_out("bp_k12", 1, bp_exp[11]);
      step(1'b0, 0);
      chk_out("bp_end", 0, 4);

      // Gap of 10 idle cycles between two accepted 1s
      do_reset();
      step(1'b1, 1);
      for (int k = 1; k <= 4; k++) begin
         step(1'b0, 0);
         chk_out($sformatf("gap_a%0d", k), 1, k);
      end
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 0);
         chk_out($sformatf("gap_idle%0d", k), 0, 4);
      end
      chk("gap_rdy", integer'(bus.o_ready), 1);
      step(1'b1, 1);
      chk_out("gap_acc", 0, 4);
      for (int k = 1; k <= 4; k++) begin
         step(1'b0, 0);
         chk_out($sformatf("gap_b%0d", k), 1, 4);
      end
      step(1'b0, 0);
      chk_out("gap_end", 0, 4);

      // Reset in the middle of a burst
      do_reset();
      step(1'b1, 1);
      step(1'b0, 0);
      step(1'b0, 0);
      chk_out("mid_pre", 1, 2);
      chk("mid_pre_phase", integer'(bus.o_phase), 2);
      i_reset_n = 1'b0;
      #1;
      chk_out("mid_rst", 0, 0);
      chk("mid_rst_rdy",   integer'(bus.o_ready), 1);
      chk("mid_rst_phase", integer'(bus.o_phase), 0);
      #1;
      i_reset_n = 1'b1;
      run_tri("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
